conv_sequencer: RTL and testbench
=================================

CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 start  in  1  begin one full 26x26 convolution pass; sampled only in IDLE.
REQ-004 abort  in  1  synchronous cancel of the pass in progress.
REQ-005 kern_wr  in  1  weight/bias write strobe; honoured only in IDLE.
REQ-006 kern_idx  in  4  0..8 = kernel tap, 9 = bias; 10..15 ignored.
REQ-007 kern_data  in  8  unsigned weight or bias value.
REQ-008 col_rd  out  1  read strobe to the im2col buffer (6084 x 8, sync RAM, 1-cycle read latency).
REQ-009 col_addr  out  13  buffer address = pixel*9 + tap.
REQ-010 col_rdata  in  8  buffer data, valid the cycle after col_rd.
REQ-011 res_valid  out  1  result available.
REQ-012 res_ready  in  1  result sink accepts when res_valid & res_ready.
REQ-013 res_addr  out  10  output pixel index 0..675.
REQ-014 res_data  out  16  convolution result.
REQ-015 tile  out  2  quarter being processed = pixel / 169.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse at pass completion.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, ACC, WRITE, DONE.
REQ-019 IDLE: start=1 -> FETCH with pixel=0, tap=0; accumulator cleared.
REQ-020 FETCH: col_rd=1, col_addr=pixel*9+tap, tap 0..8 over 9 consecutive cycles; after tap 8 -> ACC.
REQ-021 Each FETCH cycle with tap>=1 SHALL accumulate col_rdata*weight[tap-1] (8x8 unsigned -> 16-bit product).
REQ-022 ACC: accumulate col_rdata*weight[8] plus bias -> WRITE; accumulator is 20 bits, no overflow possible.
REQ-023 WRITE: res_valid=1, res_data=acc[15:0] (modulo 2^16, bit-exact with existing 16-bit PE output), res_addr=pixel; all held stable until res_ready.
REQ-024 WRITE with res_ready: pixel<675 -> pixel+1, tap=0, acc cleared, FETCH; pixel=675 -> DONE.
REQ-025 DONE: done=1 for exactly one cycle -> IDLE.
REQ-026 Timing: start sampled at edge 0 -> col_rd cycles 1..9, ACC cycle 10, res_valid first at cycle 11; unstalled pixel period 11 cycles; done at cycle 7437.
REQ-027 No col_rd SHALL be issued outside FETCH; during a WRITE stall col_rd=0.
REQ-028 tile SHALL increment when pixel crosses 169, 338, 507 (separate 0..168 counter, no divider).
REQ-029 start while busy ignored; kern_wr while busy ignored; weights persist across passes.
REQ-030 abort=1 in any non-IDLE state -> IDLE next cycle, no done pulse, res_valid drops; abort has priority over res_ready and start.
REQ-031 abort in IDLE has no effect; start and abort together in IDLE -> stays IDLE.

Reset
REQ-032 reset SHALL immediately force IDLE; col_rd, res_valid, busy, done = 0; col_addr, res_addr, res_data, tile, counters, accumulator = 0.
REQ-033 Weight and bias registers SHALL reset to 0.
REQ-034 Reset mid-pass abandons the pass; no done; next start begins at pixel 0.

Structure
REQ-035 Shared package conv_pkg SHALL hold OUT_DIM=26, N_PIX=676, K_TAPS=9, TILE_PIX=169, COL_DEPTH=6084, the address/result widths and the FSM state enum.
REQ-036 One sub-module conv_mac (8x8 multiply, 20-bit accumulator with clear/enable/bias-add) SHALL be instantiated; FSM, counters and weight registers live in conv_sequencer.

Verification
REQ-037 All weights 1, bias 0, buffer all 1 -> 676 results of 9, res_addr 0..675 in order, done at cycle 7437.
REQ-038 All weights 255, bias 255, buffer all 255 -> every res_data = 0xEF08 (585480 mod 65536).
REQ-039 res_ready low 5 cycles at pixel 0 -> res_valid/res_data/res_addr stable, col_rd=0, done delayed by exactly 5 cycles.
REQ-040 abort at pixel 300 in FETCH -> IDLE next cycle, no done; subsequent start completes a full correct pass.
REQ-041 reset asserted mid-FETCH -> all outputs at reset values without waiting for a clock edge; weights read back 0.
REQ-042 start and kern_wr(idx 0, 7) during a pass -> ignored, results unchanged; tile reads 1, 2, 3 first at pixels 169, 338, 507.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and FSM state type for the 26x26 convolution
// sequencer and its MAC datapath.
package conv_pkg;

  localparam int unsigned OUT_DIM   = 26;
  localparam int unsigned N_PIX     = OUT_DIM * OUT_DIM;   // 676
  localparam int unsigned K_TAPS    = 9;
  localparam int unsigned TILE_PIX  = N_PIX / 4;           // 169
  localparam int unsigned COL_DEPTH = N_PIX * K_TAPS;      // 6084

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 13;   // col buffer address
  localparam int unsigned PIX_W  = 10;   // output pixel index
  localparam int unsigned RES_W  = 16;   // result width
  localparam int unsigned ACC_W  = 20;   // accumulator width
  localparam int unsigned TAP_W  = 4;
  localparam int unsigned TILE_W = 2;
  localparam int unsigned TCNT_W = 8;    // pixel-within-tile counter

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ACC,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/conv_mac.sv
// conv_mac: 8x8 unsigned multiply feeding a 20-bit accumulator.
// Ports:
//   clk, reset         clock, async active-high reset
//   clr                clear accumulator (wins over en)
//   en                 accumulate din*weight (+ bias when add_bias)
//   add_bias           add bias alongside the product this cycle
//   din, weight, bias  8-bit unsigned operands
//   result             low 16 bits of the accumulator
module conv_mac
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic              add_bias,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] weight,
  input  logic [DATA_W-1:0] bias,
  output logic [RES_W-1:0]  result
);

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    addend;
  logic [ACC_W-1:0]    acc;

  always_comb begin
    prod   = (2*DATA_W)'(din) * (2*DATA_W)'(weight);
    addend = ACC_W'(prod);
    if (add_bias)
      addend = addend + ACC_W'(bias);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (en)
      acc <= acc + addend;
  end

  // 9 * 255*255 + 255 fits in 20 bits; output is the 16-bit PE view.
  assign result = acc[RES_W-1:0];

endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer: walks 676 output pixels of a 26x26 convolution, reading
// 9 im2col taps per pixel from a sync-read buffer and emitting one result
// per pixel through a valid/ready handshake.
// Ports:
//   clk, reset                     clock, async active-high reset
//   start, abort                   begin pass (IDLE only) / cancel pass
//   kern_wr, kern_idx, kern_data   weight (idx 0..8) / bias (idx 9) writes, IDLE only
//   col_rd, col_addr, col_rdata    im2col buffer read port (1-cycle latency)
//   res_valid, res_ready           result handshake
//   res_addr, res_data             result pixel index and value
//   tile                           quarter of the image being processed
//   busy, done                     activity flag / end-of-pass pulse
module conv_sequencer
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              kern_wr,
  input  logic [TAP_W-1:0]  kern_idx,
  input  logic [DATA_W-1:0] kern_data,
  output logic              col_rd,
  output logic [ADDR_W-1:0] col_addr,
  input  logic [DATA_W-1:0] col_rdata,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [PIX_W-1:0]  res_addr,
  output logic [RES_W-1:0]  res_data,
  output logic [TILE_W-1:0] tile,
  output logic              busy,
  output logic              done
);

  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(N_PIX - 1);
  localparam logic [TAP_W-1:0]  LAST_TAP  = TAP_W'(K_TAPS - 1);
  localparam logic [TCNT_W-1:0] LAST_TCNT = TCNT_W'(TILE_PIX - 1);

  state_t              state;
  logic [PIX_W-1:0]    pixel;
  logic [TAP_W-1:0]    tap;
  logic [TCNT_W-1:0]   tile_cnt;
  logic [DATA_W-1:0]   weight [K_TAPS];
  logic [DATA_W-1:0]   bias;
  logic [DATA_W-1:0]   w_sel;
  logic                mac_clr;
  logic                mac_en;
  logic                mac_bias;

  // Data for tap t arrives one cycle after its read, so FETCH at tap t
  // accumulates tap t-1 and ACC absorbs the last tap plus the bias.
  always_comb begin
    w_sel = '0;
    if (state == ACC) begin
      w_sel = weight[K_TAPS-1];
    end else begin
      for (int unsigned i = 0; i < K_TAPS - 1; i++)
        if (tap == TAP_W'(i + 1))
          w_sel = weight[i];
    end
  end

  assign mac_clr  = (state == IDLE) || ((state == WRITE) && res_ready);
  assign mac_en   = ((state == FETCH) && (tap != '0)) || (state == ACC);
  assign mac_bias = (state == ACC);

  conv_mac u_mac (
    .clk      (clk),
    .reset    (reset),
    .clr      (mac_clr),
    .en       (mac_en),
    .add_bias (mac_bias),
    .din      (col_rdata),
    .weight   (w_sel),
    .bias     (bias),
    .result   (res_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pixel     <= '0;
      tap       <= '0;
      tile_cnt  <= '0;
      tile      <= '0;
      col_rd    <= 1'b0;
      col_addr  <= '0;
      res_valid <= 1'b0;
      res_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bias      <= '0;
      for (int unsigned i = 0; i < K_TAPS; i++)
        weight[i] <= '0;
    end else begin
      done <= 1'b0;
      if ((state != IDLE) && abort) begin
        state     <= IDLE;
        col_rd    <= 1'b0;
        res_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (kern_wr) begin
              for (int unsigned i = 0; i < K_TAPS; i++)
                if (kern_idx == TAP_W'(i))
                  weight[i] <= kern_data;
              if (kern_idx == TAP_W'(K_TAPS))
                bias <= kern_data;
            end
            if (start && !abort) begin
              state    <= FETCH;
              pixel    <= '0;
              tap      <= '0;
              tile_cnt <= '0;
              tile     <= '0;
              col_addr <= '0;
              col_rd   <= 1'b1;
              busy     <= 1'b1;
            end
          end

          FETCH: begin
            if (tap == LAST_TAP) begin
              state  <= ACC;
              col_rd <= 1'b0;
            end else begin
              tap      <= tap + 1'b1;
              col_addr <= col_addr + 1'b1;
            end
          end

          ACC: begin
            state     <= WRITE;
            res_valid <= 1'b1;
            res_addr  <= pixel;
          end

          WRITE: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              if (pixel == LAST_PIX) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state  <= FETCH;
                pixel  <= pixel + 1'b1;
                tap    <= '0;
                col_rd <= 1'b1;
                // pixel*9+8 is followed directly by (pixel+1)*9+0, so the
                // address register simply keeps counting across pixels.
                col_addr <= col_addr + 1'b1;
                if (tile_cnt == LAST_TCNT) begin
                  tile_cnt <= '0;
                  tile     <= tile + 1'b1;
                end else begin
                  tile_cnt <= tile_cnt + 1'b1;
                end
              end
            end
          end

          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end

          default: begin
            state     <= IDLE;
            col_rd    <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: randomized self-checking bench for conv_sequencer with
// a behavioural im2col buffer and a per-pixel dot-product reference model.
module tb_conv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        kern_wr;
  logic [3:0]  kern_idx;
  logic [7:0]  kern_data;
  logic        col_rd;
  logic [12:0] col_addr;
  logic [7:0]  col_rdata;
  logic        res_valid;
  logic        res_ready;
  logic [9:0]  res_addr;
  logic [15:0] res_data;
  logic [1:0]  tile;
  logic        busy;
  logic        done;

  logic [7:0]  mem [0:6083];
  int          w_m [9];
  int          b_m;
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] last_res;

  conv_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .kern_wr   (kern_wr),
    .kern_idx  (kern_idx),
    .kern_data (kern_data),
    .col_rd    (col_rd),
    .col_addr  (col_addr),
    .col_rdata (col_rdata),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_addr  (res_addr),
    .res_data  (res_data),
    .tile      (tile),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read im2col buffer, one cycle of latency.
  always @(posedge clk)
    if (col_rd && col_addr < 13'd6084)
      col_rdata <= mem[col_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_pix(input int p);
    int s;
    s = b_m;
    for (int t = 0; t < 9; t++)
      s += int'(mem[9*p+t]) * w_m[t];
    return 16'(s);
  endfunction

  task automatic kern_write(input int idx, input int data);
    @(negedge clk);
    kern_wr   = 1'b1;
    kern_idx  = 4'(idx);
    kern_data = 8'(data);
    @(negedge clk);
    kern_wr = 1'b0;
    if (idx < 9)       w_m[idx] = data & 255;
    else if (idx == 9) b_m      = data & 255;
  endtask

  task automatic fill_mem(input bit rnd, input int val);
    for (int i = 0; i < 6084; i++)
      mem[i] = rnd ? 8'($urandom_range(255)) : 8'(val);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col_rd"},    col_rd,    0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
    check({tag, "_col_addr"},  col_addr,  0);
    check({tag, "_res_addr"},  res_addr,  0);
    check({tag, "_res_data"},  res_data,  0);
    check({tag, "_tile"},      tile,      0);
  endtask

  // stall_mode: 0 always ready, 1 five-cycle stall at pixel 0, 2 random stalls.
  // abort_pix >= 0 aborts the pass at that pixel (FETCH tap 4, or WRITE if abort_wr).
  task automatic run_pass(input int stall_mode, input bit inject,
                          input int abort_pix, input bit abort_wr);
    int cyc, stalls, nres, done_cyc, first_valid, first_rd, dcnt;
    bit prev_stall, ready, done_seen;
    logic [15:0] prev_data;
    logic [9:0]  prev_addr;
    stalls = 0; nres = 0; done_cyc = -1; first_valid = -1; first_rd = -1;
    prev_stall = 0; done_seen = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 9000) begin
      if (inject && cyc == 501) begin
        start   = 1'b0;
        kern_wr = 1'b0;
      end
      if (col_rd && first_rd < 0) first_rd = cyc;
      if (prev_stall) begin
        check("stall_valid", res_valid, 1);
        check("stall_data",  res_data,  prev_data);
        check("stall_addr",  res_addr,  prev_addr);
      end
      if (done) begin
        done_cyc  = cyc;
        done_seen = 1;
        break;
      end
      if (abort_pix >= 0 &&
          (abort_wr ? (res_valid && nres == abort_pix)
                    : (col_rd && col_addr == 13'(abort_pix*9 + 4)))) begin
        abort     = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        res_ready = 1'b0;
        check("abort_busy",      busy,      0);
        check("abort_res_valid", res_valid, 0);
        check("abort_col_rd",    col_rd,    0);
        dcnt = 0;
        repeat (20) begin
          @(negedge clk);
          if (done || busy) dcnt++;
        end
        check("abort_quiet", dcnt, 0);
        return;
      end
      if (res_valid) begin
        check("rd_during_write", col_rd, 0);
        if (first_valid < 0) first_valid = cyc;
        case (stall_mode)
          1:       ready = !(nres == 0 && stalls < 5);
          2:       ready = ($urandom_range(3) != 0);
          default: ready = 1'b1;
        endcase
        res_ready = ready;
        if (ready) begin
          check("res_addr", res_addr, nres);
          check("res_data", res_data, model_pix(nres));
          check("tile",     tile,     nres / 169);
          last_res = res_data;
          nres++;
          prev_stall = 0;
        end else begin
          stalls++;
          prev_stall = 1;
          prev_data  = res_data;
          prev_addr  = res_addr;
        end
      end else begin
        res_ready = 1'b0;
        prev_stall = 0;
      end
      if (inject && cyc == 500) begin
        start     = 1'b1;
        kern_wr   = 1'b1;
        kern_idx  = 4'd0;
        kern_data = 8'd7;
      end
      @(negedge clk);
      cyc++;
    end
    res_ready = 1'b0;
    check("done_seen",   done_seen,   1);
    check("n_results",   nres,        676);
    check("first_col_rd", first_rd,   1);
    check("first_valid", first_valid, 11);
    check("done_cycle",  done_cyc,    7437 + stalls);
    @(negedge clk);
    check("done_pulse_end", done, 0);
    check("idle_busy",      busy, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; kern_wr = 1'b0;
    kern_idx = '0; kern_data = '0; res_ready = 1'b0;
    for (int t = 0; t < 9; t++) w_m[t] = 0;
    b_m = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    // all ones: every result 9
    for (int t = 0; t < 9; t++) kern_write(t, 1);
    kern_write(9, 0);
    fill_mem(0, 1);
    run_pass(0, 0, -1, 0);
    check("ones_last", last_res, 16'd9);

    // saturating operands wrap modulo 2^16
    for (int t = 0; t < 9; t++) kern_write(t, 255);
    kern_write(9, 255);
    fill_mem(0, 255);
    run_pass(0, 0, -1, 0);
    check("max_last", last_res, 16'hEF08);

    // five-cycle sink stall on the first result
    run_pass(1, 0, -1, 0);

    // abort alone, and start together with abort, leave IDLE untouched
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("idle_abort_busy", busy, 0);
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("start_abort_busy",   busy,   0);
    check("start_abort_col_rd", col_rd, 0);

    // random kernel and image, random stalls, start/kern_wr while busy
    for (int t = 0; t < 9; t++) kern_write(t, $urandom_range(255));
    kern_write(9, $urandom_range(255));
    kern_write(12, $urandom_range(255));
    fill_mem(1, 0);
    run_pass(2, 1, -1, 0);

    // abort in FETCH at pixel 300, then a full pass
    run_pass(0, 0, 300, 0);
    run_pass(2, 0, -1, 0);

    // abort while a result is offered and the sink is ready
    run_pass(0, 0, 5, 1);

    // reset mid-FETCH: outputs clear asynchronously, weights return to 0
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    reset = 1'b0;
    for (int t = 0; t < 9; t++) w_m[t] = 0;
    b_m = 0;
    fill_mem(1, 0);
    run_pass(0, 0, -1, 0);
    check("zero_weights_last", last_res, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
